// File: rtl/voice_mixer_pkg.sv
// Shared constants and waveform codes for the voice mixer and related audio blocks.
package voice_mixer_pkg;

    localparam int PHASE_W  = 10;
    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 18;
    localparam int VOICE_W  = 8;
    localparam int GAIN_W   = 8;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_MUTE   = 2'd3
    } wave_e;

endpackage

// File: rtl/voice_mixer_if.sv
// Phase stream in from the DDS accumulator, mixed sample out to the DAC/PWM stage.
interface voice_mixer_if;
    import voice_mixer_pkg::*;

    logic        [PHASE_W-1:0]  phase_in;
    logic        [VOICE_W-1:0]  phase_voice;
    logic                       phase_valid;
    logic        [1:0]          wave_sel;
    logic        [GAIN_W-1:0]   voice_gain;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_valid;

    // Producer side (DDS / testbench)
    modport master (
        output phase_in, phase_voice, phase_valid, wave_sel, voice_gain,
        input  sample_out, sample_valid
    );

    // Mixer side
    modport slave (
        input  phase_in, phase_voice, phase_valid, wave_sel, voice_gain,
        output sample_out, sample_valid
    );

endinterface

// File: rtl/voice_mixer_wave_shaper.sv
// Combinational phase -> signed amplitude shaper; kept standalone so an LFO can reuse it.
module wave_shaper
    import voice_mixer_pkg::*;
(
    input  logic        [PHASE_W-1:0] i_phase,
    input  logic        [1:0]         i_wave,
    output logic signed [PHASE_W-1:0] o_amp
);

    // Triangle folds the upper half of the phase back down.
    logic [PHASE_W-2:0] w_fold;
    assign w_fold = i_phase[PHASE_W-1] ? ~i_phase[PHASE_W-2:0] : i_phase[PHASE_W-2:0];

    // Select the waveform; all results are centred on zero.
    always_comb begin
        o_amp = '0;
        case (i_wave)
            WAVE_SAW:    o_amp = i_phase - 10'd512;
            WAVE_SQUARE: o_amp = i_phase[PHASE_W-1] ? -10'sd511 : 10'sd511;
            WAVE_TRI:    o_amp = {w_fold, 1'b0} - 10'd512;
            WAVE_MUTE:   o_amp = '0;
            default:     o_amp = '0;
        endcase
    end

endmodule

// File: rtl/voice_mixer.sv
// Three-stage voice mixer: shape+register (S1), gain multiply (S2), accumulate/emit (S3).
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int OUT_SHIFT  = 4,
    parameter int ACC_W      = 22
)(
    input  logic          clk,
    input  logic          reset,
    voice_mixer_if.slave  s_mix
);

    localparam logic [VOICE_W:0]          LP_NV   = (VOICE_W+1)'(NUM_VOICES);
    localparam logic [VOICE_W-1:0]        LP_LAST = VOICE_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0]   LP_SMAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0]   LP_SMIN = ACC_W'(-32768);

    // r_vld_pipe[0] qualifies S1, r_vld_pipe[1] qualifies S2 (feeding the accumulator).
    logic        [1:0]          r_vld_pipe;
    logic signed [PHASE_W-1:0]  r_s1_amp;
    logic        [GAIN_W-1:0]   r_s1_gain;
    logic        [VOICE_W-1:0]  r_s1_voice;
    logic signed [PROD_W-1:0]   r_s2_prod;
    logic        [VOICE_W-1:0]  r_s2_voice;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic                       r_sample_vld;

    logic                       w_in_vld;
    logic signed [PHASE_W-1:0]  w_amp;
    logic signed [PROD_W-1:0]   w_amp_x;
    logic signed [PROD_W-1:0]   w_gain_x;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_shifted;
    logic signed [SAMPLE_W-1:0] w_sat;

    // Out-of-range voice indices never enter the pipe.
    assign w_in_vld = s_mix.phase_valid && ({1'b0, s_mix.phase_voice} < LP_NV);

    wave_shaper u_shaper (
        .i_phase (s_mix.phase_in),
        .i_wave  (s_mix.wave_sel),
        .o_amp   (w_amp)
    );

    // Gain is unsigned, so zero-extend it; the 18-bit product is exact.
    assign w_amp_x    = {{(PROD_W-PHASE_W){r_s1_amp[PHASE_W-1]}}, r_s1_amp};
    assign w_gain_x   = {{(PROD_W-GAIN_W){1'b0}}, r_s1_gain};
    assign w_prod     = w_amp_x * w_gain_x;

    // Voice 0 opens a new frame, discarding any partial sum.
    assign w_prod_ext = {{(ACC_W-PROD_W){r_s2_prod[PROD_W-1]}}, r_s2_prod};
    assign w_sum      = (r_s2_voice == '0) ? w_prod_ext : r_acc + w_prod_ext;
    assign w_shifted  = w_sum >>> OUT_SHIFT;

    // Clamp the scaled frame sum into the 16-bit sample range.
    always_comb begin
        w_sat = w_shifted[SAMPLE_W-1:0];
        if (w_shifted > LP_SMAX)
            w_sat = 16'sh7FFF;
        else if (w_shifted < LP_SMIN)
            w_sat = 16'sh8000;
    end

    // Valid shift register for S1/S2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_vld_pipe <= '0;
        else        r_vld_pipe <= {r_vld_pipe[0], w_in_vld};
    end

    // S1: capture shaped amplitude, gain and voice for accepted entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_amp   <= '0;
            r_s1_gain  <= '0;
            r_s1_voice <= '0;
        end else if (w_in_vld) begin
            r_s1_amp   <= w_amp;
            r_s1_gain  <= s_mix.voice_gain;
            r_s1_voice <= s_mix.phase_voice;
        end
    end

    // S2: register the gain product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_prod  <= '0;
            r_s2_voice <= '0;
        end else if (r_vld_pipe[0]) begin
            r_s2_prod  <= w_prod;
            r_s2_voice <= r_s1_voice;
        end
    end

    // S3: accumulate; the last voice closes the frame and emits one strobed sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc        <= '0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample_vld <= 1'b0;
            if (r_vld_pipe[1]) begin
                r_acc <= w_sum;
                if (r_s2_voice == LP_LAST) begin
                    r_sample     <= w_sat;
                    r_sample_vld <= 1'b1;
                end
            end
        end
    end

    assign s_mix.sample_out   = r_sample;
    assign s_mix.sample_valid = r_sample_vld;

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized + directed bench for voice_mixer; two DUTs (OUT_SHIFT 4 and 0) share one stimulus.
module tb_voice_mixer;

    localparam int NV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    // Expected strobes keyed by the cycle they must appear in.
    int   exp4[int];
    int   exp0[int];
    int   held4 = 0;
    int   held0 = 0;
    int   m_sum = 0;

    voice_mixer_if if4();
    voice_mixer_if if0();

    voice_mixer #(.NUM_VOICES(NV), .OUT_SHIFT(4), .ACC_W(22)) u_dut4 (
        .clk   (clk),
        .reset (rst_n),
        .s_mix (if4.slave)
    );

    voice_mixer #(.NUM_VOICES(NV), .OUT_SHIFT(0), .ACC_W(22)) u_dut0 (
        .clk   (clk),
        .reset (rst_n),
        .s_mix (if0.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_amp(input int wave, input int ph);
        case (wave)
            0:       return ph - 512;
            1:       return (ph >= 512) ? -511 : 511;
            2:       return (ph < 512) ? (2 * ph - 512) : (2 * (1023 - ph) - 512);
            default: return 0;
        endcase
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Drive one cycle of stimulus to both DUTs and advance the frame model.
    task automatic drive(input bit v, input int voice, input int wave, input int ph, input int gain);
        if4.phase_valid = v;        if0.phase_valid = v;
        if4.phase_voice = 8'(voice); if0.phase_voice = 8'(voice);
        if4.wave_sel    = 2'(wave);  if0.wave_sel    = 2'(wave);
        if4.phase_in    = 10'(ph);   if0.phase_in    = 10'(ph);
        if4.voice_gain  = 8'(gain);  if0.voice_gain  = 8'(gain);
        if (v && rst_n && voice < NV) begin
            if (voice == 0) m_sum = 0;
            m_sum += ref_amp(wave, ph) * gain;
            if (voice == NV - 1) begin
                exp4[cyc + 3] = sat16(m_sum >>> 4);
                exp0[cyc + 3] = sat16(m_sum);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input bit v, input int voice);
        drive(v, voice, $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_rand(1'b0, $urandom_range(0, 3));
    endtask

    task automatic frame_uniform(input int wave, input int ph, input int gain);
        for (int v = 0; v < NV; v++) begin
            drive(1'b1, v, wave, ph, gain);
            idle(1);
        end
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        exp4.delete();
        exp0.delete();
        held4 = 0;
        held0 = 0;
        m_sum = 0;
    endtask

    // Per-cycle monitor: strobe presence and held sample value on both DUTs.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vld4", {31'b0, if4.sample_valid}, exp4.exists(cyc));
            if (exp4.exists(cyc)) begin held4 = exp4[cyc]; exp4.delete(cyc); end
            chk("smp4", $signed(if4.sample_out), held4);
            chk("vld0", {31'b0, if0.sample_valid}, exp0.exists(cyc));
            if (exp0.exists(cyc)) begin held0 = exp0[cyc]; exp0.delete(cyc); end
            chk("smp0", $signed(if0.sample_out), held0);
        end
    end

    initial begin
        enter_reset();
        drive(1'b0, 0, 0, 0, 0);
        chk_en = 1'b1;

        // Reset held with phase_valid pulsing: outputs stay zero.
        for (int i = 0; i < 8; i++) drive_rand(i[0] == 1'b0, i % NV);
        rst_n = 1'b1;
        idle(2);

        // Saw frame.
        frame_uniform(0, 'h300, 16);
        idle(4);
        chk("saw_s4", $signed(if4.sample_out), 1024);

        // Triangle / mute mix.
        drive(1'b1, 0, 2, 'h100, 1);   idle(1);
        drive(1'b1, 1, 2, 'h1FF, 2);   idle(1);
        drive(1'b1, 2, 3, $urandom_range(0, 1023), $urandom_range(1, 255)); idle(1);
        drive(1'b1, 3, 0, 'h200, 255);
        idle(4);
        chk("tri_s0", $signed(if0.sample_out), 1020);
        chk("tri_s4", $signed(if4.sample_out), 63);

        // Saturation both directions.
        frame_uniform(1, 'h000, 255);
        idle(4);
        chk("satp_s0", $signed(if0.sample_out), 32767);
        chk("satp_s4", $signed(if4.sample_out), 32576);
        frame_uniform(1, 'h200, 255);
        idle(4);
        chk("satn_s0", $signed(if0.sample_out), -32768);
        chk("satn_s4", $signed(if4.sample_out), -32577);

        // Zero gain contributes nothing regardless of waveform.
        for (int v = 0; v < NV; v++) drive(1'b1, v, $urandom_range(0, 2), $urandom_range(0, 1023), 0);
        idle(4);
        chk("gain0_s0", $signed(if0.sample_out), 0);

        // Three back-to-back frames, one voice per cycle.
        for (int f = 0; f < 3; f++)
            for (int v = 0; v < NV; v++) drive_rand(1'b1, v);

        // Voice 0 restart mid-frame.
        drive_rand(1'b1, 0); drive_rand(1'b1, 1); drive_rand(1'b1, 2);
        for (int v = 0; v < NV; v++) drive_rand(1'b1, v);
        idle(4);

        // Out-of-range voice interleaved, and alone as a would-be last voice.
        drive_rand(1'b1, 0); drive_rand(1'b1, 7); drive_rand(1'b1, 1);
        drive_rand(1'b1, 7); drive_rand(1'b1, 2); drive_rand(1'b1, 3);
        drive_rand(1'b1, 7);
        idle(4);

        // Last voice without voice 0: continues the running sum.
        drive_rand(1'b1, 1); drive_rand(1'b1, 3);
        idle(4);

        // Reset mid-frame, then a clean frame.
        drive(1'b1, 0, 0, 'h300, 16);
        drive(1'b1, 1, 0, 'h300, 16);
        enter_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        frame_uniform(0, 'h300, 16);
        idle(4);
        chk("rst_mid_s4", $signed(if4.sample_out), 1024);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            int vi;
            vi = $urandom_range(0, NV);
            if (vi == NV) vi = 7;
            drive_rand($urandom_range(0, 3) != 0, vi);
        end
        idle(6);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
